demux1to5: RTL and testbench
============================

DEMUX1TO5 -- requirements
Module: demux1to5

Interface
REQ-001 SHALL have parameter: size, 32, data width of input and of each output lane.
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: in_valid  input  1  input word offered.
REQ-005 SHALL have port: in_ready  output  1  input word accepted this cycle when in_valid is also high.
REQ-006 SHALL have port: in_sel  input  3  destination lane; values 0-4 are legal, 5-7 are illegal.
REQ-007 SHALL have port: in_data  input  size  input word.
REQ-008 SHALL have port: out_valid  output  5  per-lane word present; bit k belongs to lane k.
REQ-009 SHALL have port: out_ready  input  5  per-lane consumer accept.
REQ-010 SHALL have port: out_data  output  5*size  lane k data at bits [k*size +: size].
REQ-011 SHALL have port: drop  output  1  registered one-cycle pulse after an illegal-select word is consumed.
REQ-012 SHALL have port: drop_cnt  output  8  illegal-select word count; present only under DEMUX_DROP_CNT_EN.

Function
REQ-013 SHALL hold one register slot per lane: a valid bit and a size-bit data register.
REQ-014 SHALL define a transfer as in_valid & in_ready at a rising clk edge.
REQ-015 SHALL drive in_ready combinationally: 1 when in_sel is 5-7; otherwise ~out_valid[in_sel] | out_ready[in_sel].
REQ-016 SHALL have no combinational path from in_valid or in_data to in_ready.
REQ-017 SHALL, on a transfer with legal in_sel k, set out_valid[k] to 1 and load lane k data with in_data at that edge, giving 1-cycle latency.
REQ-018 SHALL clear out_valid[k] on out_valid[k] & out_ready[k] when lane k is not loaded at the same edge.
REQ-019 SHALL, on a simultaneous drain and load of lane k, keep out_valid[k] at 1 with the new data, giving full throughput per lane.
REQ-020 SHALL hold lane k data and out_valid[k] stable while out_valid[k] & ~out_ready[k].
REQ-021 SHALL leave lanes other than in_sel untouched by a transfer; their data registers retain their last value even when invalid.
REQ-022 SHALL ignore out_ready[k] when out_valid[k] is 0.
REQ-023 SHALL, on a transfer with illegal in_sel, consume the word, load no lane, and assert drop for exactly the next cycle.
REQ-024 SHALL deassert drop in every cycle that does not follow an illegal transfer; back-to-back illegal transfers give consecutive drop cycles.
REQ-025 SHALL allow a lane to drain independently of, and concurrently with, a load into a different lane.
REQ-026 SHALL produce no output change and no drop when in_valid is low, regardless of in_sel and in_data.

Reset
REQ-027 SHALL, while rst is low, force out_valid=0, out_data=0, drop=0 and drop_cnt=0 asynchronously.
REQ-028 SHALL discard any lane contents on a mid-operation reset; no word is output after reset release.
REQ-029 SHALL accept a transfer on the first rising edge after rst deasserts.

Configuration
REQ-030 SHALL, with DEMUX_DROP_CNT_EN defined, provide drop_cnt, incremented by 1 on each illegal transfer and saturating at 255.
REQ-031 SHALL, without DEMUX_DROP_CNT_EN, omit both the drop_cnt port and its counter; all other behaviour is unchanged.

Verification
REQ-032 SHALL cover basic routing: in_sel=2, in_data=0xA5A5A5A5, out_ready=0 -> next cycle out_valid=5'b00100, lane 2 reads 0xA5A5A5A5, and other lanes stay 0.
REQ-033 SHALL cover backpressure: lane 2 full, out_ready[2]=0, in_sel=2 -> in_ready=0, lane 2 data is unchanged; then raise out_ready[2] -> in_ready=1 and the new word is loaded without a bubble.
REQ-034 SHALL cover streaming: in_sel=4 for 8 cycles with out_ready[4]=1 -> 8 words, in order, on 8 consecutive cycles, out_valid[4] held at 1.
REQ-035 SHALL cover illegal select: in_sel=6 for 3 transfers -> in_ready=1, no lane is loaded, drop is high for 3 cycles, and drop_cnt=3; with 300 illegal transfers, drop_cnt=255.
REQ-036 SHALL cover mid-operation reset: lanes 0 and 3 full, rst low for 1 cycle -> out_valid=0 and out_data=0 immediately, drop_cnt=0; a transfer on the first edge after release is loaded.

Source files
------------

// File: rtl/demux1to5.sv
// demux1to5 -- routes one input word stream into five independently drained lanes.
//
// Each lane is a single register slot (valid bit + data word). A word offered
// with in_sel 0-4 is written into that lane when the lane is empty or being
// drained in the same cycle, so a lane sustains one word per cycle. Words with
// in_sel 5-7 are always accepted and discarded; each discard raises drop for
// the following cycle.
//
// Optional feature macro: DEMUX_DROP_CNT_EN adds the drop_cnt port and a
// saturating 8-bit count of discarded words.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   input word offered
//   in_ready   input word accepted (combinational from in_sel, lane state, out_ready)
//   in_sel     destination lane, 0-4 legal, 5-7 discarded
//   in_data    input word
//   out_valid  per-lane word present, bit k = lane k
//   out_ready  per-lane consumer accept
//   out_data   lane k data at [k*size +: size]
//   drop       one-cycle pulse after a discarded word
//   drop_cnt   saturating discard count (DEMUX_DROP_CNT_EN only)

module demux1to5 #(
  parameter int unsigned size = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_sel,
  input  logic [size-1:0]       in_data,
  output logic [4:0]            out_valid,
  input  logic [4:0]            out_ready,
  output logic [5*size-1:0]     out_data,
  output logic                  drop
`ifdef DEMUX_DROP_CNT_EN
  ,
  output logic [7:0]            drop_cnt
`endif
);

  localparam int unsigned NUM_LANES = 5;
  localparam int unsigned SEL_W     = 3;
  localparam int unsigned CNT_W     = 8;
  localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(NUM_LANES - 1);

  // lane storage
  logic [NUM_LANES-1:0] valid_q;
  logic [NUM_LANES-1:0] valid_d;
  logic [size-1:0]      data_q [NUM_LANES];
  logic [size-1:0]      data_d [NUM_LANES];
  logic                 drop_q;
  logic                 drop_d;

  // input-side decode
  logic [NUM_LANES-1:0] sel_oh_c;
  logic [NUM_LANES-1:0] lane_free_c;
  logic [NUM_LANES-1:0] load_c;
  logic                 sel_illegal_c;
  logic                 xfer_c;

  // Select decode; only depends on in_sel so in_ready never sees in_valid/in_data.
  assign sel_illegal_c = (in_sel > LAST_LANE);

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_sel
    assign sel_oh_c[k] = (in_sel == SEL_W'(k));
  end

  // A lane can take a word if empty or emptying this cycle.
  assign lane_free_c = ~valid_q | out_ready;

  assign in_ready = sel_illegal_c | (|(sel_oh_c & lane_free_c));
  assign xfer_c   = in_valid & in_ready;
  assign load_c   = sel_oh_c & {NUM_LANES{xfer_c}};

  // Next-state: a load wins over a drain so simultaneous drain+load keeps the lane full.
  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < NUM_LANES; k++) begin
      data_d[k] = data_q[k];
      if (load_c[k]) begin
        valid_d[k] = 1'b1;
        data_d[k]  = in_data;
      end else if (valid_q[k] & out_ready[k]) begin
        valid_d[k] = 1'b0;
      end
    end
    drop_d = xfer_c & sel_illegal_c;
  end

  // State register; data is cleared on reset so out_data reads zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      drop_q  <= 1'b0;
      for (int k = 0; k < NUM_LANES; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      drop_q  <= drop_d;
      for (int k = 0; k < NUM_LANES; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign out_valid = valid_q;
  assign drop      = drop_q;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_out
    assign out_data[k*size +: size] = data_q[k];
  end

`ifdef DEMUX_DROP_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating discard counter, stepped by the same event that raises drop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (drop_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign drop_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_demux1to5.sv
module tb_demux1to5;

  localparam int unsigned W = 32;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [2:0]     in_sel;
  logic [W-1:0]   in_data;
  logic [4:0]     out_valid;
  logic [4:0]     out_ready;
  logic [5*W-1:0] out_data;
  logic           drop;
`ifdef DEMUX_DROP_CNT_EN
  logic [7:0]     drop_cnt;
`endif

  demux1to5 #(.size(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .drop      (drop)
`ifdef DEMUX_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one slot per lane, pending drop flag, discard count.
  bit           m_valid [5];
  logic [W-1:0] m_data  [5];
  bit           m_drop;
  int           m_cnt;
  logic         rdy_seen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] lane(input int k);
    return out_data[k*W +: W];
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 5; k++) begin
      m_valid[k] = 1'b0;
      m_data[k]  = '0;
    end
    m_drop = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic check_outputs(input string tag);
    logic [4:0] ev;
    for (int k = 0; k < 5; k++) ev[k] = m_valid[k];
    check({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
    for (int k = 0; k < 5; k++) begin
      check($sformatf("%s.lane%0d", tag, k), 64'(lane(k)), 64'(m_data[k]));
    end
    check({tag, ".drop"}, 64'(drop), 64'(m_drop));
`ifdef DEMUX_DROP_CNT_EN
    check({tag, ".drop_cnt"}, 64'(drop_cnt), 64'(m_cnt));
`endif
  endtask

  // One clock cycle: drive, check in_ready, clock, update model, check outputs.
  task automatic step(input string tag, input logic v, input logic [2:0] s,
                      input logic [W-1:0] d, input logic [4:0] r);
    bit exp_rdy;
    bit accept;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    #1;
    exp_rdy  = (s > 3'd4) ? 1'b1 : (!m_valid[s] || r[s]);
    rdy_seen = in_ready;
    check({tag, ".in_ready"}, 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    accept = v && exp_rdy;
    for (int k = 0; k < 5; k++) begin
      if (accept && (int'(s) == k)) begin
        m_valid[k] = 1'b1;
        m_data[k]  = d;
      end else if (m_valid[k] && r[k]) begin
        m_valid[k] = 1'b0;
      end
    end
    m_drop = accept && (s > 3'd4);
    if (m_drop && m_cnt < 255) m_cnt++;
    #1;
    check_outputs(tag);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_data   = '0;
    out_ready = '0;
    model_clear();
    #1;
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.out_data", 64'(out_data == '0), 64'd1);
    check("reset.drop", 64'(drop), 64'd0);
`ifdef DEMUX_DROP_CNT_EN
    check("reset.drop_cnt", 64'(drop_cnt), 64'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Basic routing into lane 2.
    step("route", 1'b1, 3'd2, 32'hA5A5A5A5, 5'b00000);
    check("route.valid_const", 64'(out_valid), 64'(5'b00100));
    check("route.lane2_const", 64'(lane(2)), 64'hA5A5A5A5);
    check("route.others_zero", 64'(lane(0) | lane(1) | lane(3) | lane(4)), 64'd0);

    // Backpressure: lane 2 full and stalled.
    step("bp_hold", 1'b1, 3'd2, 32'h11112222, 5'b00000);
    check("bp_hold.rdy_const", 64'(rdy_seen), 64'd0);
    check("bp_hold.lane2_const", 64'(lane(2)), 64'hA5A5A5A5);
    // Consumer accepts: new word replaces old with no bubble.
    step("bp_go", 1'b1, 3'd2, 32'h11112222, 5'b00100);
    check("bp_go.rdy_const", 64'(rdy_seen), 64'd1);
    check("bp_go.lane2_const", 64'(lane(2)), 64'h11112222);
    check("bp_go.valid2_const", 64'(out_valid[2]), 64'd1);
    step("bp_drain", 1'b0, 3'd0, 32'h0, 5'b00100);

    // Streaming 8 words through lane 4.
    for (int i = 0; i < 8; i++) begin
      step("stream", 1'b1, 3'd4, W'(32'h4000 + i), 5'b10000);
      check("stream.valid4_const", 64'(out_valid[4]), 64'd1);
      check("stream.lane4_const", 64'(lane(4)), 64'(32'h4000 + i));
    end
    step("stream_end", 1'b0, 3'd4, 32'hDEADBEEF, 5'b10000);
    check("stream_end.valid4_const", 64'(out_valid[4]), 64'd0);

    // Illegal select: three consumed words, three drop cycles.
    for (int i = 0; i < 3; i++) begin
      step("illegal", 1'b1, 3'd6, 32'hBAD0 + W'(i), 5'b00000);
      check("illegal.rdy_const", 64'(rdy_seen), 64'd1);
      check("illegal.drop_const", 64'(drop), 64'd1);
      check("illegal.valid_const", 64'(out_valid), 64'd0);
    end
`ifdef DEMUX_DROP_CNT_EN
    check("illegal.cnt3_const", 64'(drop_cnt), 64'd3);
`endif
    step("illegal_idle", 1'b0, 3'd7, 32'hFFFFFFFF, 5'b00000);
    check("illegal_idle.drop_const", 64'(drop), 64'd0);
    for (int i = 0; i < 300; i++) begin
      step("illegal_sat", 1'b1, 3'(5 + (i % 3)), $urandom, 5'b00000);
    end
`ifdef DEMUX_DROP_CNT_EN
    check("illegal_sat.cnt_const", 64'(drop_cnt), 64'd255);
`endif

    // Mid-operation reset with lanes 0 and 3 full.
    step("pre_rst0", 1'b1, 3'd0, 32'h0000AAAA, 5'b00000);
    step("pre_rst3", 1'b1, 3'd3, 32'h0003BBBB, 5'b00000);
    check("pre_rst.valid_const", 64'(out_valid), 64'(5'b01001));
    rst = 1'b0;
    model_clear();
    #1;
    check("midrst.out_valid", 64'(out_valid), 64'd0);
    check("midrst.out_data", 64'(out_data == '0), 64'd1);
    check("midrst.drop", 64'(drop), 64'd0);
`ifdef DEMUX_DROP_CNT_EN
    check("midrst.drop_cnt", 64'(drop_cnt), 64'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;
    step("post_rst", 1'b1, 3'd1, 32'h12345678, 5'b00000);
    check("post_rst.valid_const", 64'(out_valid), 64'(5'b00010));
    check("post_rst.lane1_const", 64'(lane(1)), 64'h12345678);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           W'($urandom), 5'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
